// File: rtl/vending_machine_nf.sv
// vending_machine_nf: cola vending controller, price 2.5 units, 0.5/1-unit coins.
// One-hot credit register with registered Mealy vend/change pulses.
module vending_machine_nf (
    input  logic sys_clk,
    input  logic sysRst,
    input  logic piOne,
    input  logic piHalf,
    output logic OCola,
    output logic change1
);
    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        HALF     = 5'b00010,
        ONE      = 5'b00100,
        ONE_HALF = 5'b01000,
        TWO      = 5'b10000
    } state_t;
    state_t state;
    logic [1:0] w_money;
    logic       w_half;
    logic       w_one;
    assign w_money = {piOne, piHalf};
    assign w_half  = w_money == 2'b01;
    assign w_one   = w_money == 2'b10;
    always_ff @(posedge sys_clk or posedge sysRst) begin
        if (sysRst) begin
            state   <= IDLE;
            OCola   <= 1'b0;
            change1 <= 1'b0;
        end else begin
            OCola   <= 1'b0;
            change1 <= 1'b0;
            case (state)
                IDLE:     state <= w_half ? HALF : w_one ? ONE : IDLE;
                HALF:     state <= w_half ? ONE : w_one ? ONE_HALF : HALF;
                ONE:      state <= w_half ? ONE_HALF : w_one ? TWO : ONE;
                ONE_HALF: begin
                    state <= w_half ? TWO : w_one ? IDLE : ONE_HALF;
                    OCola <= w_one;
                end
                TWO: begin
                    state   <= (w_half || w_one) ? IDLE : TWO;
                    OCola   <= w_half || w_one;
                    change1 <= w_one;
                end
                // non-one-hot values (upsets) fall back to an empty credit
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vending_machine_nf.sv
// tb_vending_machine_nf: vector table, hand-written corner sequences and a
// randomized run against a credit-counting reference model.
module tb_vending_machine_nf;
    logic sys_clk = 1'b0;
    logic sysRst = 1'b0;
    logic piOne = 1'b0;
    logic piHalf = 1'b0;
    logic OCola;
    logic change1;
    int   n_checks = 0;
    int   n_pass = 0;

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_HALF = 5'b00010;
    localparam logic [4:0] S_ONE  = 5'b00100;
    localparam logic [4:0] S_OH   = 5'b01000;
    localparam logic [4:0] S_TWO  = 5'b10000;

    typedef struct {
        logic       one;
        logic       half;
        logic [4:0] st;
        logic       cola;
        logic       chg;
    } vec_t;
    vec_t vecs[$];

    vending_machine_nf dut (
        .sys_clk(sys_clk),
        .sysRst(sysRst),
        .piOne(piOne),
        .piHalf(piHalf),
        .OCola(OCola),
        .change1(change1)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_all(input string name, input logic [4:0] st, input logic cola, input logic chg);
        check({name, ".state"}, dut.state, st);
        check({name, ".OCola"}, {4'b0, OCola}, {4'b0, cola});
        check({name, ".change1"}, {4'b0, change1}, {4'b0, chg});
    endtask

    task automatic drive(input logic one, input logic half);
        piOne  = one;
        piHalf = half;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sysRst = 1'b1;
        drive(1'b0, 1'b0);
        sysRst = 1'b0;
    endtask

    function automatic vec_t v(input logic one, input logic half, input logic [4:0] st,
                               input logic cola, input logic chg);
        vec_t x;
        x.one = one; x.half = half; x.st = st; x.cola = cola; x.chg = chg;
        return x;
    endfunction

    initial begin
        int credit;
        logic r, e_cola, e_chg;
        // five halves
        vecs.push_back(v(0, 1, S_HALF, 0, 0));
        vecs.push_back(v(0, 1, S_ONE,  0, 0));
        vecs.push_back(v(0, 1, S_OH,   0, 0));
        vecs.push_back(v(0, 1, S_TWO,  0, 0));
        vecs.push_back(v(0, 1, S_IDLE, 1, 0));
        vecs.push_back(v(0, 0, S_IDLE, 0, 0));
        // three ones
        vecs.push_back(v(1, 0, S_ONE,  0, 0));
        vecs.push_back(v(1, 0, S_TWO,  0, 0));
        vecs.push_back(v(1, 0, S_IDLE, 1, 1));
        vecs.push_back(v(0, 0, S_IDLE, 0, 0));
        // one, one, half
        vecs.push_back(v(1, 0, S_ONE,  0, 0));
        vecs.push_back(v(1, 0, S_TWO,  0, 0));
        vecs.push_back(v(0, 1, S_IDLE, 1, 0));
        vecs.push_back(v(0, 0, S_IDLE, 0, 0));
        // half, one, one
        vecs.push_back(v(0, 1, S_HALF, 0, 0));
        vecs.push_back(v(1, 0, S_OH,   0, 0));
        vecs.push_back(v(1, 0, S_IDLE, 1, 0));
        vecs.push_back(v(0, 0, S_IDLE, 0, 0));
        // gaps and illegal input
        vecs.push_back(v(0, 1, S_HALF, 0, 0));
        vecs.push_back(v(0, 0, S_HALF, 0, 0));
        vecs.push_back(v(0, 0, S_HALF, 0, 0));
        vecs.push_back(v(0, 0, S_HALF, 0, 0));
        vecs.push_back(v(1, 1, S_HALF, 0, 0));
        vecs.push_back(v(1, 1, S_HALF, 0, 0));
        vecs.push_back(v(1, 0, S_OH,   0, 0));
        // back-to-back vends, coin accepted while pulse high
        vecs.push_back(v(0, 1, S_TWO,  0, 0));
        vecs.push_back(v(1, 0, S_IDLE, 1, 1));
        vecs.push_back(v(0, 1, S_HALF, 0, 0));
        vecs.push_back(v(1, 0, S_OH,   0, 0));
        vecs.push_back(v(1, 0, S_IDLE, 1, 0));
        vecs.push_back(v(1, 1, S_IDLE, 0, 0));

        // reset held 2 cycles with random coins
        #1;
        sysRst = 1'b1;
        #1;
        check_all("rst_async", S_IDLE, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_all("rst_hold", S_IDLE, 0, 0);
        end
        sysRst = 1'b0;
        drive(1'b0, 1'b1);
        check_all("rst_release_coin", S_HALF, 0, 0);

        do_reset();
        check_all("table_start", S_IDLE, 0, 0);
        foreach (vecs[i]) begin
            drive(vecs[i].one, vecs[i].half);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cola, vecs[i].chg);
        end

        // mid-transaction reset at TWO discards credit
        do_reset();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        check_all("pre_rst_two", S_TWO, 0, 0);
        piOne = 1'b1;
        #2;
        sysRst = 1'b1;
        #1;
        check_all("mid_rst", S_IDLE, 0, 0);
        drive(1'b1, 1'b0);
        check_all("mid_rst_held", S_IDLE, 0, 0);
        sysRst = 1'b0;
        drive(1'b1, 1'b0);
        check_all("post_rst_1", S_ONE, 0, 0);
        drive(1'b1, 1'b0);
        check_all("post_rst_2", S_TWO, 0, 0);
        drive(1'b1, 1'b0);
        check_all("post_rst_3", S_IDLE, 1, 1);
        drive(1'b0, 1'b0);
        check_all("post_rst_4", S_IDLE, 0, 0);

        // random alternating coins vs credit model (half-unit counts)
        do_reset();
        credit = 0;
        for (int i = 0; i < 1000; i++) begin
            r = 1'($urandom_range(0, 1));
            drive(r, ~r);
            credit += r ? 2 : 1;
            e_cola = credit >= 5;
            e_chg  = credit == 6;
            if (e_cola) credit = 0;
            check_all("rand", 5'(1 << credit), e_cola, e_chg);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
